// File: rtl/sn_packet_buffer_if.sv
// Snooper-side write/handshake and consumer-side read bundle for sn_packet_buffer.
interface sn_packet_buffer_if #(
  parameter int unsigned SN_FWD_DATA_WIDTH = 64,
  parameter int unsigned SN_FWD_ADDR_WIDTH = 9,
  parameter int unsigned INC_WIDTH         = 8,
  parameter int unsigned LEN_WIDTH         = 16
);
  logic                         rdy_for_sn;
  logic                         rdy_for_sn_ack;
  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr;
  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data;
  logic                         sn_wr_en;
  logic [INC_WIDTH-1:0]         sn_byte_inc;
  logic                         sn_done;
  logic                         pkt_ready;
  logic [LEN_WIDTH-1:0]         pkt_len;
  logic                         rd_en;
  logic [SN_FWD_ADDR_WIDTH-1:0] rd_addr;
  logic [SN_FWD_DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         rd_done;
  logic                         len_sat;

  // Buffer side.
  modport slave (
    output rdy_for_sn, pkt_ready, pkt_len, rd_data, rd_valid, len_sat,
    input  rdy_for_sn_ack, sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done,
    input  rd_en, rd_addr, rd_done
  );

  // Snooper/consumer side.
  modport master (
    input  rdy_for_sn, pkt_ready, pkt_len, rd_data, rd_valid, len_sat,
    output rdy_for_sn_ack, sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done,
    output rd_en, rd_addr, rd_done
  );
endinterface

// File: rtl/sn_packet_buffer.sv
// Single-packet buffer between the AXI-Stream snooper and the filter core:
// captures one packet into a simple dual-port RAM, tracks its byte length, hands it to the consumer.
module sn_packet_buffer #(
  parameter int unsigned SN_FWD_DATA_WIDTH = 64,
  parameter int unsigned SN_FWD_ADDR_WIDTH = 9,
  parameter int unsigned INC_WIDTH         = 8,
  parameter int unsigned LEN_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sn_packet_buffer_if.slave    bus
);

  localparam int unsigned DEPTH = 2 ** SN_FWD_ADDR_WIDTH;
  localparam int unsigned SUM_W = ((LEN_WIDTH > INC_WIDTH) ? LEN_WIDTH : INC_WIDTH) + 1;
  localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({LEN_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic                         len_sat_q, len_sat_d;
  logic                         rdy_for_sn_q, rdy_for_sn_d;
  logic                         pkt_ready_q, pkt_ready_d;
  logic                         rd_valid_q, rd_valid_d;
  logic [SN_FWD_DATA_WIDTH-1:0] rd_data_q;
  logic                         mem_we_c;
  logic [SUM_W-1:0]             len_sum_c;

  logic [SN_FWD_DATA_WIDTH-1:0] mem [DEPTH];

  // State, length and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      len_q        <= '0;
      len_sat_q    <= 1'b0;
      rdy_for_sn_q <= 1'b0;
      pkt_ready_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      len_sat_q    <= len_sat_d;
      rdy_for_sn_q <= rdy_for_sn_d;
      pkt_ready_q  <= pkt_ready_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Next-state, length accumulation and write-enable decode.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    len_sat_d = len_sat_q;
    mem_we_c  = 1'b0;
    len_sum_c = SUM_W'(len_q) + SUM_W'(bus.sn_byte_inc);

    unique case (state_q)
      ST_EMPTY: begin
        if (bus.rdy_for_sn_ack) begin
          state_d   = ST_FILL;
          len_d     = '0;
          len_sat_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (bus.sn_wr_en) begin
          mem_we_c = 1'b1;
          if (len_sum_c > LEN_MAX) begin
            len_d     = {LEN_WIDTH{1'b1}};
            len_sat_d = 1'b1;
          end else begin
            len_d = LEN_WIDTH'(len_sum_c);
          end
        end
        if (bus.sn_done) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.rd_done) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Status outputs are registered from the next state so they align with it.
    rdy_for_sn_d = (state_d == ST_EMPTY);
    pkt_ready_d  = (state_d == ST_READY);
    rd_valid_d   = bus.rd_en;
  end

  // Write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[bus.sn_addr] <= bus.sn_wr_data;
    end
  end

  // Registered read port, read-first against a same-cycle write; holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.rdy_for_sn = rdy_for_sn_q;
  assign bus.pkt_ready  = pkt_ready_q;
  assign bus.pkt_len    = len_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.len_sat    = len_sat_q;

endmodule
